// File: rtl/seq_alu.sv
// seq_alu: multi-cycle 8-bit execute unit placed after the register file.
// Logic ops, add/sub and pass-through finish in one cycle. Shifts by n > 0
// iterate one bit per clock. Multiply iterates W shift-add steps into a 2W
// accumulator. Operands are captured at start, so the register file read
// ports are free to change while the unit is busy.
module seq_alu #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero
);

    localparam int SW = $clog2(W);   // shift-count width taken from B
    localparam int CW = SW + 1;      // step counter must hold the value W

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    // Control state
    state_e          state;
    op_e             op_q;
    logic [CW-1:0]   count;

    // Iteration datapath
    logic [W-1:0]    shreg;     // shift operand, one bit per step
    logic [2*W-1:0]  acc;       // multiply partial product
    logic [2*W-1:0]  mcand;     // multiplicand, moves left each step
    logic [W-1:0]    mplier;    // multiplier, moves right each step

    // Single-cycle path
    op_e             op_in;
    logic [SW-1:0]   shamt;
    logic            iterate;
    logic [W-1:0]    fast_res;
    logic            fast_carry;
    logic [W:0]      sum_ext;

    // Iteration step path
    logic [W-1:0]    step_sh;
    logic            step_out;
    logic [2*W-1:0]  acc_next;
    logic [W-1:0]    step_res;
    logic            step_carry;
    logic            last_step;

    assign op_in     = op_e'(op);
    assign shamt     = inB[SW-1:0];
    assign last_step = (count == CW'(1));

    // Zero-step result and the decision whether the request needs RUN.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        fast_res   = '0;
        fast_carry = 1'b0;
        sum_ext    = '0;
        iterate    = 1'b0;
        case (op_in)
            OP_ADD: begin
                sum_ext    = {1'b0, inA} + {1'b0, inB};
                fast_res   = sum_ext[W-1:0];
                fast_carry = sum_ext[W];
            end
            OP_SUB: begin
                // A + ~B + 1: the carry out is the "no borrow" indication.
                sum_ext    = {1'b0, inA} + {1'b0, ~inB} + (W+1)'(1);
                fast_res   = sum_ext[W-1:0];
                fast_carry = sum_ext[W];
            end
            OP_AND:  fast_res = inA & inB;
            OP_XOR:  fast_res = inA ^ inB;
            OP_SHL,
            OP_SHR: begin
                // A zero-length shift returns A with nothing shifted out.
                fast_res = inA;
                iterate  = (shamt != '0);
            end
            OP_MUL:  iterate  = 1'b1;
            OP_PASS: fast_res = inA;
            default: fast_res = '0;
        endcase
    end

    // One iteration step for the latched shift or multiply operation.
    always_comb begin
        step_sh    = '0;
        step_out   = 1'b0;
        step_res   = '0;
        step_carry = 1'b0;
        acc_next   = mplier[0] ? (acc + mcand) : acc;
        case (op_q)
            OP_SHL: begin
                step_sh  = {shreg[W-2:0], 1'b0};
                step_out = shreg[W-1];
            end
            OP_SHR: begin
                step_sh  = {1'b0, shreg[W-1:1]};
                step_out = shreg[0];
            end
            default: begin
                step_sh  = shreg;
                step_out = 1'b0;
            end
        endcase
        if (op_q == OP_MUL) begin
            // Low half is the result; any set bit in the high half is overflow.
            step_res   = acc_next[W-1:0];
            step_carry = |acc_next[2*W-1:W];
        end else begin
            step_res   = step_sh;
            step_carry = step_out;
        end
    end

    // Sequencer and registered outputs; reset is synchronous and wins over start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge.
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= OP_ADD;
            count  <= '0;
            shreg  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (iterate) begin
                            state  <= S_RUN;
                            busy   <= 1'b1;
                            op_q   <= op_in;
                            shreg  <= inA;
                            acc    <= '0;
                            mcand  <= {{W{1'b0}}, inA};
                            mplier <= inB;
                            count  <= (op_in == OP_MUL) ? CW'(W) : CW'(shamt);
                        end else begin
                            result <= fast_res;
                            carry  <= fast_carry;
                            zero   <= (fast_res == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Requests arriving here are dropped by design.
                    count  <= count - CW'(1);
                    shreg  <= step_sh;
                    acc    <= acc_next;
                    mcand  <= {mcand[2*W-2:0], 1'b0};
                    mplier <= {1'b0, mplier[W-1:1]};
                    if (last_step) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= step_res;
                        carry  <= step_carry;
                        zero   <= (step_res == '0);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
